// File: rtl/fp_add_pkg.sv
// Shared binary32 field layout, special encodings and the adder's default latency.
package fp_add_pkg;

   localparam int FRAC_W   = 23;
   localparam int EXP_W    = 8;
   localparam int EXP_LSB  = FRAC_W;
   localparam int SIGN_POS = FRAC_W + EXP_W;
   localparam int MAN_W    = FRAC_W + 1;
   localparam int ALN_W    = MAN_W + 3;
   localparam int SUM_W    = ALN_W + 1;

   localparam int EXP_BIAS  = 127;
   localparam int EXP_INF_I = 2 * EXP_BIAS + 1;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
   localparam logic [31:0] QNAN = 32'h7FC00000;

   localparam int LAT_DEF = 3;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

   function automatic fp32_t unpack(input logic [31:0] x);
      unpack.sign = x[SIGN_POS];
      unpack.exp  = x[EXP_LSB +: EXP_W];
      unpack.frac = x[FRAC_W-1:0];
   endfunction

endpackage

// File: rtl/fp_add_lzc32.sv
// Combinational leading-zero count of a 32-bit vector; an all-zero input yields 32.
module lzc32 (
   input  logic [31:0] v_i,
   output logic [5:0]  cnt_o
);

   always_comb begin
      cnt_o = 6'd32;
      for (int i = 0; i < 32; i++) begin
         if (v_i[i]) cnt_o = 6'(31 - i);
      end
   end

endmodule

// File: rtl/fp_add.sv
// Pipelined binary32 adder/subtractor: flush-to-zero, round-to-nearest-even.
// Stage 1 unpack/align, stage 2 magnitude add, stage 3 normalize/round, then LAT-3 delay registers.
module fp_add
   import fp_add_pkg::*;
#(
   parameter int LAT = LAT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        en,
   input  logic        sub,
   output logic [31:0] y
);

   localparam int NDLY = LAT - 2;
   localparam logic signed [9:0] E_INF = 10'(EXP_INF_I);

   // Rounding carry bumps the exponent; out-of-range exponents saturate to Inf or flush to zero.
   function automatic logic [31:0] round_pack(input logic sign, input logic signed [9:0] exp,
                                              input logic [ALN_W-2:0] fgrs);
      logic [FRAC_W:0]   frac;
      logic signed [9:0] e;
      logic              up;
      up   = fgrs[2] & (fgrs[1] | fgrs[0] | fgrs[3]);
      frac = {1'b0, fgrs[ALN_W-2:3]} + {{FRAC_W{1'b0}}, up};
      e    = frac[FRAC_W] ? exp + 10'sd1 : exp;
      if (e >= E_INF)      round_pack = {sign, EXP_MAX, {FRAC_W{1'b0}}};
      else if (e <= 10'sd0) round_pack = {sign, 31'b0};
      else                 round_pack = {sign, e[EXP_W-1:0], frac[FRAC_W-1:0]};
   endfunction

   // ---- stage 1: unpack, specials, compare, align
   fp32_t             fa_1, fb_1;
   logic              sa_1, sb_1, a_big_1, spec_1;
   logic [MAN_W-1:0]  ma_1, mb_1, m_small_1;
   logic [EXP_W-1:0]  e_big_1, e_small_1, diff_1;
   logic [ALN_W-1:0]  big_1, small_ext_1, small_aln_1, sticky_mask_1;
   logic [31:0]       spec_val_1;

   always_comb begin
      fa_1      = unpack(a);
      fb_1      = unpack(b);
      sa_1      = fa_1.sign;
      sb_1      = fb_1.sign ^ sub;
      ma_1      = (fa_1.exp == '0) ? '0 : {1'b1, fa_1.frac};
      mb_1      = (fb_1.exp == '0) ? '0 : {1'b1, fb_1.frac};
      a_big_1   = {fa_1.exp, ma_1} >= {fb_1.exp, mb_1};
      e_big_1   = a_big_1 ? fa_1.exp : fb_1.exp;
      e_small_1 = a_big_1 ? fb_1.exp : fa_1.exp;
      big_1     = {(a_big_1 ? ma_1 : mb_1), 3'b000};
      m_small_1 = a_big_1 ? mb_1 : ma_1;
      diff_1    = e_big_1 - e_small_1;
      small_ext_1   = {m_small_1, 3'b000};
      sticky_mask_1 = ~({ALN_W{1'b1}} << diff_1);
      // Beyond 26 positions the smaller operand only survives as sticky.
      if (diff_1 > 8'd26)
         small_aln_1 = {{(ALN_W-1){1'b0}}, |m_small_1};
      else
         small_aln_1 = (small_ext_1 >> diff_1)
                     | {{(ALN_W-1){1'b0}}, |(small_ext_1 & sticky_mask_1)};

      spec_1     = 1'b1;
      spec_val_1 = QNAN;
      if (((fa_1.exp == EXP_MAX) && (fa_1.frac != '0)) || ((fb_1.exp == EXP_MAX) && (fb_1.frac != '0)))
         spec_val_1 = QNAN;
      else if ((fa_1.exp == EXP_MAX) && (fb_1.exp == EXP_MAX) && (sa_1 != sb_1))
         spec_val_1 = QNAN;
      else if (fa_1.exp == EXP_MAX)
         spec_val_1 = {sa_1, EXP_MAX, {FRAC_W{1'b0}}};
      else if (fb_1.exp == EXP_MAX)
         spec_val_1 = {sb_1, EXP_MAX, {FRAC_W{1'b0}}};
      else
         spec_1 = 1'b0;
   end

   logic              vld_p1_q, spec_p1_q, sign_p1_q, op_sub_p1_q;
   logic [31:0]       spec_val_p1_q;
   logic [EXP_W-1:0]  exp_p1_q;
   logic [ALN_W-1:0]  big_p1_q, small_p1_q;

   always_ff @(posedge clk) begin
      if (en) begin
         spec_p1_q     <= spec_1;
         spec_val_p1_q <= spec_val_1;
         sign_p1_q     <= a_big_1 ? sa_1 : sb_1;
         op_sub_p1_q   <= sa_1 ^ sb_1;
         exp_p1_q      <= e_big_1;
         big_p1_q      <= big_1;
         small_p1_q    <= small_aln_1;
      end
   end

   // ---- stage 2: magnitude add/subtract (big >= small, so never negative)
   logic              vld_p2_q, spec_p2_q, sign_p2_q, op_sub_p2_q;
   logic [31:0]       spec_val_p2_q;
   logic [EXP_W-1:0]  exp_p2_q;
   logic [SUM_W-1:0]  sum_p2_q;

   always_ff @(posedge clk) begin
      if (vld_p1_q) begin
         spec_p2_q     <= spec_p1_q;
         spec_val_p2_q <= spec_val_p1_q;
         sign_p2_q     <= sign_p1_q;
         op_sub_p2_q   <= op_sub_p1_q;
         exp_p2_q      <= exp_p1_q;
         sum_p2_q      <= op_sub_p1_q ? ({1'b0, big_p1_q} - {1'b0, small_p1_q})
                                      : ({1'b0, big_p1_q} + {1'b0, small_p1_q});
      end
   end

   // ---- stage 3: normalize, round, pack
   logic [5:0]        lz_3;
   logic signed [9:0] exp_3;
   logic [ALN_W-1:0]  norm_3;
   logic [31:0]       res_3;

   lzc32 u_lzc (
      .v_i   ({sum_p2_q, 4'b0000}),
      .cnt_o (lz_3)
   );

   always_comb begin
      exp_3 = $signed({2'b00, exp_p2_q}) + 10'sd1 - $signed({4'b0000, lz_3});
      if (sum_p2_q[SUM_W-1])
         norm_3 = {sum_p2_q[SUM_W-1:2], |sum_p2_q[1:0]};
      else
         norm_3 = sum_p2_q[ALN_W-1:0] << (lz_3 - 6'd1);
      // A zero magnitude leaves no leading one; cancellation gives +0.
      if (spec_p2_q)
         res_3 = spec_val_p2_q;
      else if (!norm_3[ALN_W-1])
         res_3 = {sign_p2_q & ~op_sub_p2_q, 31'b0};
      else
         res_3 = round_pack(sign_p2_q, exp_3, norm_3[ALN_W-2:0]);
   end

   // ---- stage 3 register and trailing delay line; the last entry drives y
   logic [NDLY-1:0] vin;
   logic [31:0]     res_q [NDLY];

   assign vin[0] = vld_p2_q;

   for (genvar k = 1; k < NDLY; k++) begin : g_dly_vld
      logic vld_q;
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) vld_q <= 1'b0;
         else      vld_q <= vin[k-1];
      end
      assign vin[k] = vld_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         for (int k = 0; k < NDLY; k++) res_q[k] <= '0;
      end else begin
         vld_p1_q <= en;
         vld_p2_q <= vld_p1_q;
         if (vin[0]) res_q[0] <= res_3;
         for (int k = 1; k < NDLY; k++) begin
            if (vin[k]) res_q[k] <= res_q[k-1];
         end
      end
   end

   assign y = res_q[NDLY-1];

endmodule

// File: tb/tb_fp_add.sv
// Bench for fp_add: directed vector tables, reset sequence, and random traffic vs an exact-arithmetic model.
module tb_fp_add;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic        en = 1'b0, sub = 1'b0;
   logic [31:0] y;

   int checks = 0;
   int errors = 0;
   bit auto_on = 1'b0;

   fp_add #(.LAT(LAT)) dut (
      .clk (clk), .rst (rst), .a (a), .b (b), .en (en), .sub (sub), .y (y)
   );

   always #5 clk = ~clk;

   // Exact reference: integer-align both operands, add exactly, then round once to 24 bits.
   function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] z, input logic s);
      logic sx, sz, sr;
      logic [7:0] ex, ez, e0;
      logic [299:0] vx, vz, mag, kept, rem, half;
      int p, e, sh;
      sx = x[31]; sz = z[31] ^ s; ex = x[30:23]; ez = z[30:23];
      if ((ex == 8'hFF && x[22:0] != 0) || (ez == 8'hFF && z[22:0] != 0)) return 32'h7FC00000;
      if (ex == 8'hFF && ez == 8'hFF) return (sx == sz) ? {sx, 8'hFF, 23'h0} : 32'h7FC00000;
      if (ex == 8'hFF) return {sx, 8'hFF, 23'h0};
      if (ez == 8'hFF) return {sz, 8'hFF, 23'h0};
      vx = '0; vz = '0;
      if (ex != 0) vx[23:0] = {1'b1, x[22:0]};
      if (ez != 0) vz[23:0] = {1'b1, z[22:0]};
      e0 = (ex < ez) ? ex : ez;
      vx = vx << (ex - e0);
      vz = vz << (ez - e0);
      if (sx == sz)      begin mag = vx + vz; sr = sx; end
      else if (vx >= vz) begin mag = vx - vz; sr = sx; end
      else               begin mag = vz - vx; sr = sz; end
      if (mag == 0) return {(sx == sz) ? sx : 1'b0, 31'b0};
      p = 0;
      for (int i = 0; i < 300; i++) if (mag[i]) p = i;
      e = int'(e0) + p - 23;
      if (p > 23) begin
         sh   = p - 23;
         kept = mag >> sh;
         rem  = mag & ((300'd1 << sh) - 300'd1);
         half = 300'd1 << (sh - 1);
         if (rem > half || (rem == half && kept[0])) kept = kept + 300'd1;
         if (kept[24]) begin kept = kept >> 1; e = e + 1; end
      end else begin
         kept = mag << (23 - p);
      end
      if (e >= 255) return {sr, 8'hFF, 23'h0};
      if (e <= 0)   return {sr, 31'b0};
      return {sr, 8'(e), kept[22:0]};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 19))
         0: r[30:0] = '0;
         1: r[30:0] = {8'hFF, 23'h0};
         2: r[30:23] = 8'hFF;
         3: r[30:23] = 8'h00;
         4: r[30:23] = 8'(250 + $urandom_range(0, 4));
         5: r[30:23] = 8'($urandom_range(1, 4));
         6: begin r[30:23] = 8'(120 + $urandom_range(0, 14)); r[10:0] = '0; end
         7: ;
         default: r[30:23] = 8'(110 + $urandom_range(0, 34));
      endcase
      return r;
   endfunction

   // Latency model: result of each issue appears LAT edges later; y holds otherwise.
   logic [LAT-2:0] mv;
   logic [31:0]    md [LAT-1];
   logic [31:0]    y_exp;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mv    <= '0;
         y_exp <= '0;
      end else begin
         mv    <= {mv[LAT-3:0], en};
         md[0] <= ref_add(a, b, sub);
         for (int k = 1; k < LAT - 1; k++) md[k] <= md[k-1];
         if (mv[LAT-2]) y_exp <= md[LAT-2];
      end
   end

   always @(negedge clk) begin
      if (auto_on) begin
         checks++;
         if (y !== y_exp) begin
            errors++;
            $display("FAIL model t=%0t y=%08h expected=%08h", $time, y, y_exp);
         end
      end
   end

   task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] y=%08h expected=%08h", nm, idx, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] y;
   } vec_t;

   vec_t vt [19];
   vec_t bt [5];

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      vt[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
      vt[1]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};
      vt[2]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000};
      vt[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000};
      vt[4]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002};
      vt[5]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000};
      vt[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000};
      vt[7]  = '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000};
      vt[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000};
      vt[9]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000};
      vt[10] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000};
      vt[11] = '{32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000};
      vt[12] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000};
      vt[13] = '{32'h3F800000, 32'h2F800000, 1'b0, 32'h3F800000};
      vt[14] = '{32'h3F800000, 32'h2F800000, 1'b1, 32'h3F800000};
      vt[15] = '{32'h80800000, 32'h00800001, 1'b0, 32'h00000000};
      vt[16] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000};
      vt[17] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001};
      vt[18] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000};

      bt[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000};
      bt[1] = '{32'h40000000, 32'h40000000, 1'b0, 32'h40800000};
      bt[2] = '{32'h3F000000, 32'h3E800000, 1'b1, 32'h3E800000};
      bt[3] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};
      bt[4] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};

      // Reset state, then release.
      @(negedge clk);
      check("reset_y", 0, y, 32'h0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      auto_on = 1'b1;

      // Single issues with exact-latency check on the first.
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         a = vt[i].a; b = vt[i].b; sub = vt[i].s; en = 1'b1;
         @(negedge clk);
         en = 1'b0;
         repeat (LAT - 2) @(negedge clk);
         if (i == 0) check("early", i, y, 32'h0);
         @(negedge clk);
         check("vec", i, y, vt[i].y);
      end

      // Back-to-back issues, including a repeated operand pair.
      for (int t = 0; t < 5 + LAT; t++) begin
         @(negedge clk);
         if (t >= LAT) check("b2b", t - LAT, y, bt[t-LAT].y);
         if (t < 5) begin a = bt[t].a; b = bt[t].b; sub = bt[t].s; en = 1'b1; end
         else en = 1'b0;
      end

      // Reset with 1+2 in flight: y clears at once and 3.0 never appears.
      @(negedge clk);
      a = 32'h3F800000; b = 32'h40000000; sub = 1'b0; en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      #1 rst = 1'b0;
      #1 check("rst_async", 0, y, 32'h0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      a = 32'h40000000; b = 32'h40000000; sub = 1'b0; en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      check("post_rst", 1, y, 32'h0);
      for (int k = 2; k < LAT; k++) begin
         @(negedge clk);
         check("post_rst", k, y, 32'h0);
      end
      @(negedge clk);
      check("post_rst", LAT, y, 32'h40800000);
      repeat (4) begin
         @(negedge clk);
         check("post_rst_hold", 0, y, 32'h40800000);
      end

      // Random traffic, checked every cycle against the model.
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         en  = ($urandom_range(0, 4) != 0);
         a   = rand_op();
         b   = ($urandom_range(0, 7) == 0) ? (a ^ 32'($urandom_range(0, 3))) : rand_op();
         sub = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      en = 1'b0;
      repeat (LAT + 2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_add.md
FP_ADD -- requirements
Module: fp_add

Interface
REQ-001 Parameter LAT, default 3: pipeline latency in cycles, en-cycle to result; legal values are 3 or more.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port a, input, 32 bits: operand A, IEEE-754 binary32.
REQ-005 Port b, input, 32 bits: operand B, IEEE-754 binary32.
REQ-006 Port en, input, 1 bit: issue strobe; a, b and sub are sampled when en=1.
REQ-007 Port sub, input, 1 bit: 0 computes a+b; 1 computes a-b.
REQ-008 Port y, output, 32 bits: result, binary32, driven directly from a register.

Function
REQ-009 When en=1 in cycle N, y SHALL show the result for those operands during cycle N+LAT, i.e. after exactly LAT rising edges.
REQ-010 The pipeline SHALL be fully pipelined: one issue per cycle, with results leaving in issue order on consecutive cycles.
REQ-011 The pipeline SHALL always advance; there is no stall or back-pressure input.
REQ-012 Each stage SHALL carry a valid bit; y SHALL update only when a valid result reaches the last stage and SHALL otherwise hold its last value.
REQ-013 sub=1 SHALL be implemented by inverting the sign of b before the add.
REQ-014 Normal operands: align on the exponent difference, keeping guard, round and sticky bits; add or subtract magnitudes; normalize with a leading-zero count; round to nearest, ties to even.
REQ-015 Rounding overflow of the mantissa SHALL increment the exponent.
REQ-016 Exponent overflow SHALL produce a correctly signed infinity (0x7F800000 or 0xFF800000).
REQ-017 Subnormal inputs SHALL be treated as zero of the same sign (flush-to-zero).
REQ-018 A result below the minimum normal SHALL be flushed to zero of the result sign.
REQ-019 An exact zero from operands of opposite effective sign SHALL be +0 (0x00000000).
REQ-020 (+0)+(+0) SHALL give +0 and (-0)+(-0) SHALL give -0.
REQ-021 A NaN on either input, or Inf minus Inf of the same magnitude, SHALL give canonical NaN 0x7FC00000.
REQ-022 Inf combined with any finite operand SHALL give that Inf.
REQ-023 If the exponent difference is above 26, the smaller operand SHALL contribute only the sticky bit.
REQ-024 The same operand value on both inputs in consecutive cycles SHALL give independent, identical results.

Reset
REQ-025 While rst=0, all pipeline valid bits SHALL clear and y SHALL be 0x00000000 asynchronously.
REQ-026 Operations in flight when reset asserts SHALL be discarded and never appear on y.
REQ-027 After rst is released, the first issue SHALL obey REQ-009 with no extra warm-up cycles.

Structure
REQ-028 A shared package SHALL hold the binary32 field widths and positions, EXP_BIAS=127, the canonical NaN 0x7FC00000, and the default LAT.
REQ-029 Stages: 1 unpack/special-case/compare/align; 2 magnitude add/sub; 3 normalize/round/pack.
REQ-030 When LAT>3, the extra cycles SHALL be inserted as plain delay registers after stage 3.
REQ-031 One sub-module, lzc32, SHALL provide a combinational leading-zero count of a 32-bit vector with a 6-bit output.

Verification
REQ-032 a=0x3F800000, b=0x40000000, sub=0, en for 1 cycle -> y=0x40400000 exactly LAT cycles later.
REQ-033 a=0x40400000, b=0x3F800000, sub=1 -> y=0x40000000; a=b=0x3F800000, sub=1 -> y=0x00000000.
REQ-034 Three back-to-back issues of 1+1, 2+2 and 0.5-0.25 (0x3F000000, 0x3E800000, sub=1) -> y=0x40000000, 0x40800000, 0x3E800000 on consecutive cycles.
REQ-035 Rounding: 0x3F800000+0x33800000 -> 0x3F800000 (tie to even); 0x3F800001+0x33800000 -> 0x3F800002.
REQ-036 Specials: 0x7F800000+0xFF800000 -> 0x7FC00000; 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000; 0x00400000+0x3F800000 -> 0x3F800000.
REQ-037 Reset: issue 1+2, assert rst=0 one cycle later -> y=0 immediately and no 3.0 appears after release.
